// File: rtl/read_addr_hazard_gate.sv
// Read-address hazard gate: holds a read request until no pending write in the
// 8-entry write-address window targets the same {bank, row, col}, then issues it.

`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif

module read_addr_hazard_gate #(
    parameter int unsigned DATA_WIDTH = `ROW_ADDR_BITS + `COL_ADDR_BITS + `BANK_ADDR_BITS,
    parameter int unsigned HOLD_CNT_W = 8,
    parameter int unsigned EVT_CNT_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_rd_valid,
    output logic                    o_rd_ready,
    input  logic [DATA_WIDTH-1:0]   i_rd_addr,
    input  logic [DATA_WIDTH:0]     i_waddr_0,
    input  logic [DATA_WIDTH:0]     i_waddr_1,
    input  logic [DATA_WIDTH:0]     i_waddr_2,
    input  logic [DATA_WIDTH:0]     i_waddr_3,
    input  logic [DATA_WIDTH:0]     i_waddr_4,
    input  logic [DATA_WIDTH:0]     i_waddr_5,
    input  logic [DATA_WIDTH:0]     i_waddr_6,
    input  logic [DATA_WIDTH:0]     i_waddr_7,
    output logic                    o_cmd_valid,
    input  logic                    i_cmd_ready,
    output logic [DATA_WIDTH-1:0]   o_cmd_addr,
    output logic                    o_hazard,
    output logic [HOLD_CNT_W-1:0]   o_hold_cycles,
    output logic [EVT_CNT_W-1:0]    o_hazard_events
);

    localparam int unsigned WIN_DEPTH = 8;
    localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = '1;
    localparam logic [EVT_CNT_W-1:0]  EVT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   rd_addr_q;
    logic                    rd_ready_q;
    logic [DATA_WIDTH:0]     window [WIN_DEPTH];
    logic [WIN_DEPTH-1:0]    match;
    logic                    hit;

    assign window[0] = i_waddr_0;
    assign window[1] = i_waddr_1;
    assign window[2] = i_waddr_2;
    assign window[3] = i_waddr_3;
    assign window[4] = i_waddr_4;
    assign window[5] = i_waddr_5;
    assign window[6] = i_waddr_6;
    assign window[7] = i_waddr_7;

    assign o_rd_ready = rd_ready_q;

    // Compare the captured read address against every valid window entry.
    always_comb begin
        match = '0;
        for (int k = 0; k < int'(WIN_DEPTH); k++) begin
            match[k] = window[k][DATA_WIDTH] && (window[k][DATA_WIDTH-1:0] == rd_addr_q);
        end
        hit = |match;
    end

    // Request FSM with registered handshake, hazard flag and statistics.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            rd_addr_q       <= '0;
            rd_ready_q      <= 1'b1;
            o_cmd_valid     <= 1'b0;
            o_cmd_addr      <= '0;
            o_hazard        <= 1'b0;
            o_hold_cycles   <= '0;
            o_hazard_events <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_rd_valid && rd_ready_q) begin
                        rd_addr_q     <= i_rd_addr;
                        o_hold_cycles <= '0;
                        rd_ready_q    <= 1'b0;
                        state         <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        o_hazard <= 1'b1;
                        if (o_hazard_events != EVT_MAX) begin
                            o_hazard_events <= o_hazard_events + EVT_CNT_W'(1);
                        end
                        state <= ST_HOLD;
                    end else begin
                        o_cmd_valid <= 1'b1;
                        o_cmd_addr  <= rd_addr_q;
                        state       <= ST_ISSUE;
                    end
                end
                ST_HOLD: begin
                    if (o_hold_cycles != HOLD_MAX) begin
                        o_hold_cycles <= o_hold_cycles + HOLD_CNT_W'(1);
                    end
                    if (!hit) begin
                        o_hazard    <= 1'b0;
                        o_cmd_valid <= 1'b1;
                        o_cmd_addr  <= rd_addr_q;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        rd_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_addr_hazard_gate.sv
// Directed bench for read_addr_hazard_gate: default instance plus a narrow
// hold-counter instance sharing the same stimulus.

`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif

module tb_read_addr_hazard_gate;

    localparam int unsigned DW = `ROW_ADDR_BITS + `COL_ADDR_BITS + `BANK_ADDR_BITS;

    logic          clk;
    logic          rst_n;
    logic          rd_valid;
    logic [DW-1:0] rd_addr;
    logic [DW:0]   w [8];
    logic          cmd_ready;

    logic          rd_ready;
    logic          cmd_valid;
    logic [DW-1:0] cmd_addr;
    logic          hazard;
    logic [7:0]    hold;
    logic [15:0]   events;

    logic          s_rd_ready;
    logic          s_cmd_valid;
    logic [DW-1:0] s_cmd_addr;
    logic          s_hazard;
    logic [3:0]    s_hold;
    logic [15:0]   s_events;

    int total;
    int bad;

    read_addr_hazard_gate dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_valid(rd_valid), .o_rd_ready(rd_ready),
        .i_rd_addr(rd_addr),
        .i_waddr_0(w[0]), .i_waddr_1(w[1]), .i_waddr_2(w[2]), .i_waddr_3(w[3]),
        .i_waddr_4(w[4]), .i_waddr_5(w[5]), .i_waddr_6(w[6]), .i_waddr_7(w[7]),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_addr(cmd_addr),
        .o_hazard(hazard), .o_hold_cycles(hold), .o_hazard_events(events)
    );

    read_addr_hazard_gate #(.HOLD_CNT_W(4)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_valid(rd_valid), .o_rd_ready(s_rd_ready),
        .i_rd_addr(rd_addr),
        .i_waddr_0(w[0]), .i_waddr_1(w[1]), .i_waddr_2(w[2]), .i_waddr_3(w[3]),
        .i_waddr_4(w[4]), .i_waddr_5(w[5]), .i_waddr_6(w[6]), .i_waddr_7(w[7]),
        .o_cmd_valid(s_cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_addr(s_cmd_addr),
        .o_hazard(s_hazard), .o_hold_cycles(s_hold), .o_hazard_events(s_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_window();
        for (int i = 0; i < 8; i++) w[i] = '0;
    endtask

    function automatic logic [DW:0] entry(input logic v, input logic [DW-1:0] a);
        return {v, a};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; rd_valid = 1'b0; rd_addr = '0; cmd_ready = 1'b0;
        clear_window();
        #2;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%0h want=0", cmd_valid); end
        total++; if (cmd_addr !== '0) begin bad++; $display("FAIL reset_cmd_addr got=%0h want=0", cmd_addr); end
        total++; if ({hazard, hold, events} !== '0) begin bad++; $display("FAIL reset_stats got=%0h/%0h/%0h want=0", hazard, hold, events); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL reset_rd_ready got=%0h want=1", rd_ready); end
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_cmd_valid got=%0h want=0", cmd_valid); end
    endtask

    task automatic test_no_hazard();
        rd_valid = 1'b1; rd_addr = DW'(12'h123);
        tick();
        rd_valid = 1'b0;
        total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL nohaz_ready_check got=%0h want=0", rd_ready); end
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL nohaz_valid_check got=%0h want=0", cmd_valid); end
        tick();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL nohaz_cmd_valid got=%0h want=1", cmd_valid); end
        total++; if (cmd_addr !== DW'(12'h123)) begin bad++; $display("FAIL nohaz_cmd_addr got=%0h want=123", cmd_addr); end
        total++; if ({hazard, hold, events} !== '0) begin bad++; $display("FAIL nohaz_stats got=%0h/%0h/%0h want=0", hazard, hold, events); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        total++; if (cmd_valid !== 1'b0 || rd_ready !== 1'b1) begin bad++; $display("FAIL nohaz_done got=%0h/%0h want=0/1", cmd_valid, rd_ready); end
        total++; if (cmd_addr !== DW'(12'h123)) begin bad++; $display("FAIL nohaz_addr_hold got=%0h want=123", cmd_addr); end
    endtask

    task automatic test_hazard();
        w[3] = entry(1'b1, DW'(12'h123));
        rd_valid = 1'b1; rd_addr = DW'(12'h123);
        tick();
        rd_valid = 1'b0;
        tick();
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_enter got=%0h want=1", hazard); end
        total++; if (events !== 16'd1) begin bad++; $display("FAIL haz_events got=%0h want=1", events); end
        total++; if (hold !== 8'd0) begin bad++; $display("FAIL haz_hold_start got=%0h want=0", hold); end
        tick();
        // window shifts: the pending write moves one slot toward the head
        w[3] = '0; w[2] = entry(1'b1, DW'(12'h123));
        tick();
        total++; if (hazard !== 1'b1 || cmd_valid !== 1'b0) begin bad++; $display("FAIL haz_shift got=%0h/%0h want=1/0", hazard, cmd_valid); end
        tick(); tick();
        total++; if (hold !== 8'd4) begin bad++; $display("FAIL haz_hold_mid got=%0h want=4", hold); end
        w[2] = '0;
        tick();
        total++; if (cmd_valid !== 1'b1 || hazard !== 1'b0) begin bad++; $display("FAIL haz_issue got=%0h/%0h want=1/0", cmd_valid, hazard); end
        total++; if (hold !== 8'd5) begin bad++; $display("FAIL haz_hold_final got=%0h want=5", hold); end
        w[5] = entry(1'b1, DW'(12'h123));
        tick();
        total++; if (cmd_valid !== 1'b1 || hazard !== 1'b0) begin bad++; $display("FAIL haz_issue_ignore_win got=%0h/%0h want=1/0", cmd_valid, hazard); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        w[5] = '0;
        total++; if (cmd_valid !== 1'b0 || rd_ready !== 1'b1 || hold !== 8'd5) begin bad++; $display("FAIL haz_done got=%0h/%0h/%0h want=0/1/5", cmd_valid, rd_ready, hold); end
    endtask

    task automatic test_valid_bit();
        w[0] = entry(1'b0, DW'(12'h123));
        for (int i = 1; i < 8; i++) w[i] = entry(1'b1, DW'(12'h456));
        rd_valid = 1'b1; rd_addr = DW'(12'h123);
        tick();
        rd_valid = 1'b0;
        tick();
        total++; if (cmd_valid !== 1'b1 || hazard !== 1'b0) begin bad++; $display("FAIL vbit_issue got=%0h/%0h want=1/0", cmd_valid, hazard); end
        total++; if (events !== 16'd1 || hold !== 8'd0) begin bad++; $display("FAIL vbit_stats got=%0h/%0h want=1/0", events, hold); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        clear_window();
    endtask

    task automatic test_check_drain();
        w[6] = entry(1'b1, DW'(12'h2A5));
        rd_valid = 1'b1; rd_addr = DW'(12'h2A5);
        tick();
        rd_valid = 1'b0;
        w[6] = '0;
        tick();
        total++; if (cmd_valid !== 1'b1 || hazard !== 1'b0) begin bad++; $display("FAIL drain_issue got=%0h/%0h want=1/0", cmd_valid, hazard); end
        total++; if (events !== 16'd1) begin bad++; $display("FAIL drain_events got=%0h want=1", events); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        rd_valid = 1'b1; rd_addr = DW'(12'h3C7);
        tick();
        rd_addr = DW'(12'h111);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (cmd_valid !== 1'b1 || cmd_addr !== DW'(12'h3C7) || rd_ready !== 1'b0) begin
                bad++; $display("FAIL bp_stall%0d got=%0h/%0h/%0h want=1/3c7/0", i, cmd_valid, cmd_addr, rd_ready);
            end
        end
        rd_valid = 1'b0;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        total++; if (cmd_valid !== 1'b0 || rd_ready !== 1'b1) begin bad++; $display("FAIL bp_done got=%0h/%0h want=0/1", cmd_valid, rd_ready); end
        tick();
        total++; if (cmd_valid !== 1'b0 || rd_ready !== 1'b1) begin bad++; $display("FAIL bp_single got=%0h/%0h want=0/1", cmd_valid, rd_ready); end
    endtask

    task automatic test_back_to_back();
        cmd_ready = 1'b1;
        rd_valid = 1'b1; rd_addr = DW'(12'h0AA);
        tick();
        rd_addr = DW'(12'h0BB);
        total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL b2b_a_accept got=%0h want=0", rd_ready); end
        tick();
        total++; if (cmd_valid !== 1'b1 || cmd_addr !== DW'(12'h0AA)) begin bad++; $display("FAIL b2b_a_issue got=%0h/%0h want=1/aa", cmd_valid, cmd_addr); end
        tick();
        total++; if (cmd_valid !== 1'b0 || rd_ready !== 1'b1) begin bad++; $display("FAIL b2b_a_done got=%0h/%0h want=0/1", cmd_valid, rd_ready); end
        tick();
        rd_valid = 1'b0;
        total++; if (rd_ready !== 1'b0 || cmd_addr !== DW'(12'h0AA)) begin bad++; $display("FAIL b2b_b_accept got=%0h/%0h want=0/aa", rd_ready, cmd_addr); end
        tick();
        total++; if (cmd_valid !== 1'b1 || cmd_addr !== DW'(12'h0BB)) begin bad++; $display("FAIL b2b_b_issue got=%0h/%0h want=1/bb", cmd_valid, cmd_addr); end
        tick();
        cmd_ready = 1'b0;
        total++; if (cmd_valid !== 1'b0 || rd_ready !== 1'b1) begin bad++; $display("FAIL b2b_b_done got=%0h/%0h want=0/1", cmd_valid, rd_ready); end
    endtask

    task automatic test_saturation();
        w[1] = entry(1'b1, DW'(12'h055));
        rd_valid = 1'b1; rd_addr = DW'(12'h055);
        tick();
        rd_valid = 1'b0;
        tick();
        total++; if (s_hazard !== 1'b1 || s_hold !== 4'd0) begin bad++; $display("FAIL sat_enter got=%0h/%0h want=1/0", s_hazard, s_hold); end
        for (int i = 0; i < 16; i++) tick();
        total++; if (s_hold !== 4'd15) begin bad++; $display("FAIL sat_hold_16 got=%0h want=f", s_hold); end
        for (int i = 0; i < 3; i++) tick();
        total++; if (s_hold !== 4'd15 || hold !== 8'd19) begin bad++; $display("FAIL sat_hold_19 got=%0h/%0h want=f/13", s_hold, hold); end
        total++; if (s_cmd_valid !== 1'b0) begin bad++; $display("FAIL sat_no_early_issue got=%0h want=0", s_cmd_valid); end
        w[1] = '0;
        tick();
        total++; if (s_cmd_valid !== 1'b1 || s_cmd_addr !== DW'(12'h055) || s_hazard !== 1'b0) begin bad++; $display("FAIL sat_issue got=%0h/%0h/%0h want=1/55/0", s_cmd_valid, s_cmd_addr, s_hazard); end
        total++; if (s_hold !== 4'd15 || hold !== 8'd20) begin bad++; $display("FAIL sat_hold_final got=%0h/%0h want=f/14", s_hold, hold); end
        total++; if (events !== 16'd2) begin bad++; $display("FAIL sat_events got=%0h want=2", events); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        w[7] = entry(1'b1, DW'(12'h321));
        rd_valid = 1'b1; rd_addr = DW'(12'h321);
        tick();
        rd_valid = 1'b0;
        tick(); tick(); tick();
        total++; if (hazard !== 1'b1 || events !== 16'd3) begin bad++; $display("FAIL rsthold_pre got=%0h/%0h want=1/3", hazard, events); end
        rst_n = 1'b0;
        #1;
        total++; if ({cmd_valid, cmd_addr, hazard, hold, events} !== '0) begin
            bad++; $display("FAIL rsthold_async got=%0h/%0h/%0h/%0h/%0h want=0", cmd_valid, cmd_addr, hazard, hold, events);
        end
        total++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL rsthold_ready got=%0h want=1", rd_ready); end
        tick();
        rst_n = 1'b1;
        w[7] = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (cmd_valid !== 1'b0 || rd_ready !== 1'b1 || events !== 16'd0) begin
                bad++; $display("FAIL rsthold_after%0d got=%0h/%0h/%0h want=0/1/0", i, cmd_valid, rd_ready, events);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_no_hazard();
        test_hazard();
        test_valid_bit();
        test_check_drain();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/read_addr_hazard_gate.md
Name: read_addr_hazard_gate

Overview:
- Read-side counterpart of the write-address FIFO.
- Accepts one read request at a time and checks its {bank, row, col} address against the 8-entry write-address window exported by the write-address FIFO. Window entries are oldest to newest; each carries a valid bit.
- On a match, the read is held until every matching pending write has drained. Only then is the read issued downstream, so read-after-write ordering is preserved.
- Sits between the frontend read-command path and the command scheduler.

Parameters:
- DATA_WIDTH, default `ROW_ADDR_BITS+`COL_ADDR_BITS+`BANK_ADDR_BITS: address width, {bank, row, col}.
- HOLD_CNT_W, default 8: width of the per-request hold-cycle counter.
- EVT_CNT_W, default 16: width of the hazard-event counter.

Ports:
- i_clk  input  1  clock; the only clock in the block.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rd_valid  input  1  read request valid.
- o_rd_ready  output  1  block can accept a read request.
- i_rd_addr  input  DATA_WIDTH  read address {bank, row, col}.
- i_waddr_0..i_waddr_7  input  DATA_WIDTH+1 each  write-window entries.
  - Bit [DATA_WIDTH] is the valid bit; the lower bits are the address.
  - Entry 0 is the oldest.
- o_cmd_valid  output  1  issued read valid.
- i_cmd_ready  input  1  scheduler accepts the issued read.
- o_cmd_addr  output  DATA_WIDTH  issued read address.
- o_hazard  output  1  high while the current read is held.
- o_hold_cycles  output  HOLD_CNT_W  hold cycles spent by the current or last read.
- o_hazard_events  output  EVT_CNT_W  total reads that encountered a hazard.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state=IDLE, rd_addr_q=0;
  - o_cmd_valid=0, o_cmd_addr=0, o_hazard=0;
  - o_hold_cycles=0, o_hazard_events=0.
- o_rd_ready = (state==IDLE). It is therefore 1 immediately after reset release.
- Match vector, computed every cycle: match[k] = i_waddr_k[DATA_WIDTH] && (i_waddr_k[DATA_WIDTH-1:0] == rd_addr_q). hit = |match.
  - An entry with valid=0 never matches, even when its address bits are equal.
- FSM has 4 states:
  - IDLE: on i_rd_valid && o_rd_ready, capture i_rd_addr into rd_addr_q, clear o_hold_cycles, go to CHECK.
  - CHECK (1 cycle): if hit, go to HOLD and increment o_hazard_events (saturating at all-ones). Otherwise go to ISSUE.
  - HOLD: o_hazard=1. o_hold_cycles increments every cycle in HOLD, saturating at all-ones.
    - hit is re-evaluated every cycle against the live window, which shifts as writes enter.
    - When hit=0, go to ISSUE.
  - ISSUE: o_cmd_valid=1, o_cmd_addr=rd_addr_q.
    - Hold both stable while i_cmd_ready=0.
    - On i_cmd_ready=1, go to IDLE and drop o_cmd_valid next cycle.
    - Window changes during ISSUE are ignored.
- Latency:
  - Request accepted at edge N; o_cmd_valid is high from edge N+2 when there is no hazard.
  - With a hazard: N+2+H, where H is the number of HOLD cycles.
- Throughput: at most one read per 3 cycles.
- o_rd_ready is 0 in CHECK, HOLD and ISSUE. i_rd_valid is ignored in those states; the upstream side holds its request.
- o_cmd_addr is registered and holds its last value in IDLE. o_hold_cycles holds its value until the next accept.
- Simultaneous events:
  - A write drains in the same cycle as CHECK: the combinational hit for that cycle decides.
  - A new matching write appears in the same cycle that HOLD would exit: stay in HOLD (hit=1).
- Reset mid-operation (any state) aborts the request. No command is issued, and all outputs return to reset values.
- Counter wrap: none. Both counters saturate.

Test Plan:
- No hazard: all window entries valid=0; read 0x123 accepted at cycle 0 -> o_cmd_valid=1 from cycle 2 with o_cmd_addr=0x123, o_hazard=0, o_hold_cycles=0, o_hazard_events=0.
- Hazard in entry 3 (i_waddr_3={1,0x123}); read 0x123 accepted at cycle 0:
  - o_hazard=1 from cycle 2;
  - the entry's valid is cleared at cycle 6 -> o_cmd_valid at cycle 7;
  - o_hold_cycles=5, o_hazard_events=1.
- Valid bit respected: i_waddr_0={0,0x123}, other entries {1,0x456}; read 0x123 -> issued at cycle 2, no hazard.
- Backpressure: i_cmd_ready=0 for 4 cycles during ISSUE -> o_cmd_valid and o_cmd_addr stable, o_rd_ready=0. Single handshake on ready, then IDLE.
- Saturation, with HOLD_CNT_W=4: hazard held 20 cycles -> o_hold_cycles stops at 15, command issues one cycle after hit clears.
- Reset in HOLD: assert i_rst_n=0 for 1 cycle -> all outputs 0 at once. After release, o_rd_ready=1, o_hazard_events=0, no stray o_cmd_valid.
